// File: rtl/eth_rx_hdr_parse_if.sv
// Bus bundle for the Ethernet RX header parser: input byte stream, header
// handshake and payload stream. "master" is the parser, "slave" is its surroundings.
interface eth_rx_hdr_parse_if;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic        s_axis_tuser;

   logic        m_eth_hdr_valid;
   logic        m_eth_hdr_ready;
   logic [47:0] m_eth_dest_mac;
   logic [47:0] m_eth_src_mac;
   logic [15:0] m_eth_type;

   logic [7:0]  m_eth_payload_axis_tdata;
   logic        m_eth_payload_axis_tvalid;
   logic        m_eth_payload_axis_tready;
   logic        m_eth_payload_axis_tlast;
   logic        m_eth_payload_axis_tuser;

   modport master (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      output s_axis_tready,
      output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
      input  m_eth_hdr_ready,
      output m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
      output m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
      input  m_eth_payload_axis_tready
   );

   modport slave (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      input  s_axis_tready,
      input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
      output m_eth_hdr_ready,
      input  m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
      input  m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
      output m_eth_payload_axis_tready
   );
endinterface

// File: rtl/eth_rx_hdr_parse.sv
// Strips the 14-byte Ethernet header from each RX frame, presents MACs and
// EtherType on a header handshake and forwards the payload as a byte stream.
module eth_rx_hdr_parse #(
   parameter bit          TYPE_FILTER_ENABLE = 1'b0,
   parameter logic [15:0] TYPE_FILTER_VALUE  = 16'h0800
) (
   input  logic               clk,
   input  logic               rst_n,
   eth_rx_hdr_parse_if.master eth,
   output logic               busy,
   output logic               error_header_early_termination
);

   typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

   state_t       state_q, state_d;
   logic [3:0]   hdr_cnt_q, hdr_cnt_d;
   logic [111:0] shadow_q, shadow_d;
   logic         run_q;
   logic         hdr_vld_q, hdr_vld_d;
   logic [47:0]  dest_q, dest_d;
   logic [47:0]  src_q, src_d;
   logic [15:0]  type_q, type_d;
   logic [7:0]   pl_data_q, pl_data_d;
   logic         pl_vld_q, pl_vld_d;
   logic         pl_last_q, pl_last_d;
   logic         pl_user_q, pl_user_d;
   logic         err_q, err_d;
   logic         s_ready;
   logic         s_fire;

   // run_q keeps s_axis_tready low while reset is held and for the first cycle after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HDR;
         hdr_cnt_q <= '0;
         shadow_q  <= '0;
         run_q     <= 1'b0;
         hdr_vld_q <= 1'b0;
         dest_q    <= '0;
         src_q     <= '0;
         type_q    <= '0;
         pl_data_q <= '0;
         pl_vld_q  <= 1'b0;
         pl_last_q <= 1'b0;
         pl_user_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hdr_cnt_q <= hdr_cnt_d;
         shadow_q  <= shadow_d;
         run_q     <= 1'b1;
         hdr_vld_q <= hdr_vld_d;
         dest_q    <= dest_d;
         src_q     <= src_d;
         type_q    <= type_d;
         pl_data_q <= pl_data_d;
         pl_vld_q  <= pl_vld_d;
         pl_last_q <= pl_last_d;
         pl_user_q <= pl_user_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hdr_cnt_d = hdr_cnt_q;
      shadow_d  = shadow_q;
      hdr_vld_d = hdr_vld_q;
      dest_d    = dest_q;
      src_d     = src_q;
      type_d    = type_q;
      pl_data_d = pl_data_q;
      pl_vld_d  = pl_vld_q;
      pl_last_d = pl_last_q;
      pl_user_d = pl_user_q;
      err_d     = 1'b0;
      s_ready   = 1'b0;

      if (hdr_vld_q && eth.m_eth_hdr_ready) hdr_vld_d = 1'b0;
      if (eth.m_eth_payload_axis_tready)    pl_vld_d  = 1'b0;

      case (state_q)
         HDR:     s_ready = run_q && !hdr_vld_q;
         PAYLOAD: s_ready = run_q && (eth.m_eth_payload_axis_tready || !pl_vld_q);
         DROP:    s_ready = run_q;
         default: s_ready = 1'b0;
      endcase
      s_fire = s_ready && eth.s_axis_tvalid;

      if (s_fire) begin
         case (state_q)
            HDR: begin
               for (int i = 0; i < 14; i++) begin
                  if (hdr_cnt_q == 4'(i)) shadow_d[111-8*i -: 8] = eth.s_axis_tdata;
               end
               if (eth.s_axis_tlast) begin
                  err_d     = 1'b1;
                  hdr_cnt_d = '0;
               end else if (hdr_cnt_q == 4'd13) begin
                  hdr_cnt_d = '0;
                  // Byte 13 completes the EtherType, so decide from the next-state shadow.
                  if (TYPE_FILTER_ENABLE && (shadow_d[15:0] != TYPE_FILTER_VALUE)) begin
                     state_d = DROP;
                  end else begin
                     dest_d    = shadow_d[111:64];
                     src_d     = shadow_d[63:16];
                     type_d    = shadow_d[15:0];
                     hdr_vld_d = 1'b1;
                     state_d   = PAYLOAD;
                  end
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 4'd1;
               end
            end
            PAYLOAD: begin
               pl_data_d = eth.s_axis_tdata;
               pl_last_d = eth.s_axis_tlast;
               pl_user_d = eth.s_axis_tlast && eth.s_axis_tuser;
               pl_vld_d  = 1'b1;
               if (eth.s_axis_tlast) begin
                  hdr_cnt_d = '0;
                  state_d   = HDR;
               end
            end
            DROP: begin
               if (eth.s_axis_tlast) begin
                  hdr_cnt_d = '0;
                  state_d   = HDR;
               end
            end
            default: state_d = HDR;
         endcase
      end
   end

   assign eth.s_axis_tready             = s_ready;
   assign eth.m_eth_hdr_valid           = hdr_vld_q;
   assign eth.m_eth_dest_mac            = dest_q;
   assign eth.m_eth_src_mac             = src_q;
   assign eth.m_eth_type                = type_q;
   assign eth.m_eth_payload_axis_tdata  = pl_data_q;
   assign eth.m_eth_payload_axis_tvalid = pl_vld_q;
   assign eth.m_eth_payload_axis_tlast  = pl_last_q;
   assign eth.m_eth_payload_axis_tuser  = pl_user_q;

   assign busy                           = (state_q != HDR) || (hdr_cnt_q != 4'd0);
   assign error_header_early_termination = err_q;

endmodule

// File: doc/eth_rx_hdr_parse.md
Name: eth_rx_hdr_parse

Overview:
- Sits directly downstream of the MII MAC RX FIFO output (`rx_axis_*`, 8-bit, `tuser` = bad frame) in the logic clock domain.
- Strips the 14-byte Ethernet header from each received frame.
- Presents destination MAC, source MAC and EtherType on a separate header handshake, and forwards the remaining payload bytes as an AXI-Stream.
- Optional EtherType filter silently discards unwanted frames.

Parameters:
- TYPE_FILTER_ENABLE, 0, 1 = drop frames whose EtherType != TYPE_FILTER_VALUE.
- TYPE_FILTER_VALUE, 16'h0800, EtherType accepted when filtering is enabled.

Ports:
- clk  in  1  logic clock; all logic is posedge clk.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  8  frame byte from RX FIFO.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tready  out  1  input byte accepted.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  bad-frame flag, meaningful with tlast.
- m_eth_hdr_valid  out  1  header fields valid.
- m_eth_hdr_ready  in  1  header consumer ready.
- m_eth_dest_mac  out  48  destination MAC; byte 0 in bits [47:40].
- m_eth_src_mac  out  48  source MAC; byte 6 in bits [47:40].
- m_eth_type  out  16  EtherType; byte 12 in bits [15:8].
- m_eth_payload_axis_tdata  out  8  payload byte.
- m_eth_payload_axis_tvalid  out  1  payload valid.
- m_eth_payload_axis_tready  in  1  payload consumer ready.
- m_eth_payload_axis_tlast  out  1  last payload byte.
- m_eth_payload_axis_tuser  out  1  copied from s_axis_tuser on the last byte.
- busy  out  1  high in any state other than HDR with byte count 0.
- error_header_early_termination  out  1  one-cycle pulse on a frame shorter than 15 bytes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0: tvalid, hdr_valid, error, busy, s_axis_tready and all field registers.
  - The state machine enters HDR with hdr_cnt (4-bit) = 0.
  - Reset mid-frame abandons the frame; no error pulse is produced.
- A transfer occurs on any cycle where valid and ready are both high. Registered outputs hold stable while valid is high and ready is low.
- State HDR:
  - s_axis_tready = !m_eth_hdr_valid, so a new header waits until the previous one is accepted.
  - Each accepted byte is stored at index hdr_cnt into a 112-bit shadow register, then hdr_cnt increments.
  - tlast on a byte with hdr_cnt <= 13 (frame of 14 bytes or fewer):
    - pulse error_header_early_termination the next cycle;
    - no header is emitted;
    - hdr_cnt returns to 0.
  - Byte 13 accepted without tlast:
    - if the filter is enabled and the type mismatches, go to DROP;
    - otherwise load the output fields, set m_eth_hdr_valid the next cycle, and go to PAYLOAD.
- State PAYLOAD:
  - Single output register stage, with s_axis_tready = m_eth_payload_axis_tready || !m_eth_payload_axis_tvalid.
  - Latency is 1 cycle from input acceptance to tvalid.
  - tdata, tlast and tuser are copied. tuser is forced to 0 unless tlast is set.
  - On an accepted byte with tlast, hdr_cnt goes to 0 and the state goes to HDR.
  - Payload forwarding does not wait for header acceptance. Header and payload handshakes are independent.
- State DROP:
  - s_axis_tready = 1.
  - Bytes are discarded; no payload and no header are produced.
  - On an accepted tlast, go to HDR with hdr_cnt = 0.
- m_eth_hdr_valid clears on the cycle after hdr_valid && hdr_ready. Fields are unchanged until the next header is loaded.
- Simultaneous events:
  - The header handshake completing and a new frame's byte 0 in the same cycle: byte 0 is not accepted that cycle (ready was low); it is accepted the following cycle.
  - Payload register draining and refilling in the same cycle is permitted, giving full throughput of 1 byte/cycle.
- Back-to-back frames: the first header byte of frame N+1 may be accepted on the cycle after frame N's last payload byte is accepted, provided the frame N header has already been taken.
- An input tuser on a header-only or short frame does not affect behaviour beyond the error pulse.

Test Plan:
- 60-byte frame, dest ff:ff:ff:ff:ff:ff, src 02:00:00:00:00:01, type 0x0806, both consumers always ready:
  - dest=48'hffffffffffff, src=48'h020000000001, type=16'h0806;
  - 46 payload bytes match input bytes 14..59;
  - tlast on the 46th payload byte; no error pulse.
- 10-byte frame with tlast on byte 9:
  - error_header_early_termination is high for exactly 1 cycle;
  - no hdr_valid, no payload;
  - the next good frame parses correctly.
- Exactly 14-byte frame: error pulse, no header, no payload output.
- TYPE_FILTER_ENABLE=1, VALUE=0x0800:
  - a 0x86DD frame produces no header and no payload;
  - an immediately following 0x0800 frame is emitted intact.
- Random backpressure on m_eth_payload_axis_tready (50%) and m_eth_hdr_ready held low for 100 cycles:
  - 3 back-to-back frames are received with no loss or duplication;
  - s_axis_tready stays low at frame 2 byte 0 until header 1 is accepted.
- Frame with tuser=1 on tlast gives m_eth_payload_axis_tuser=1 on the last payload byte only. Asserting rst_n low mid-payload clears all valids asynchronously and busy=0.
